// File: rtl/cp_pkg.sv
// Shared definitions for the Command Processor sequencer: GX opcodes, fetch
// sizes and the parser FSM states.
package cp_pkg;

  localparam logic [7:0] CP_OP_NOP        = 8'h00;
  localparam logic [7:0] CP_OP_LOAD_CP    = 8'h08;
  localparam logic [7:0] CP_OP_LOAD_XF    = 8'h10;
  localparam logic [7:0] CP_OP_LOAD_BP    = 8'h61;
  localparam logic [7:0] CP_OP_INV_VC     = 8'h48;
  localparam logic [7:0] CP_OP_CALL_DL    = 8'h40;
  // Draw opcodes are 0b10pp_pvvv: primitive in [5:3], VAT index in [2:0].
  localparam logic [7:0] CP_OP_DRAW_MASK  = 8'hC0;
  localparam logic [7:0] CP_OP_DRAW_MATCH = 8'h80;

  localparam logic [2:0] CP_BYTES_1 = 3'd1;
  localparam logic [2:0] CP_BYTES_2 = 3'd2;
  localparam logic [2:0] CP_BYTES_4 = 3'd4;

  typedef enum logic [3:0] {
    StOpcode,
    StCpAddr,
    StCpData,
    StXfHdr,
    StXfData,
    StBpData,
    StDlAddr,
    StDlSize,
    StDrawCount,
    StDraw
  } cp_state_e;

  // Fetch size for each parser state; StDraw is sized by the vertex loader.
  function automatic logic [2:0] state_bytes(input cp_state_e st);
    case (st)
      StOpcode, StCpAddr: state_bytes = CP_BYTES_1;
      StDrawCount:        state_bytes = CP_BYTES_2;
      default:            state_bytes = CP_BYTES_4;
    endcase
  endfunction

endpackage

// File: rtl/cp_opcode_decoder.sv
// Combinational GX opcode decoder: maps an opcode byte to the parser state that
// fetches its operands, extracts draw fields and flags unknown opcodes.
// Display-list call (0x40) is decoded only when CP_DISPLAY_LIST_EN is defined.
module cp_opcode_decoder
  import cp_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [3:0] next_state,
  output logic [2:0] prim,
  output logic [2:0] vat,
  output logic       unknown
);

  assign prim = opcode[5:3];
  assign vat  = opcode[2:0];

  // Operand-fetch state for the opcode; unrecognised bytes return to StOpcode.
  always_comb begin
    next_state = StOpcode;
    unknown    = 1'b0;
    if ((opcode & CP_OP_DRAW_MASK) == CP_OP_DRAW_MATCH) begin
      next_state = StDrawCount;
    end else begin
      case (opcode)
        CP_OP_NOP, CP_OP_INV_VC: next_state = StOpcode;
        CP_OP_LOAD_CP:           next_state = StCpAddr;
        CP_OP_LOAD_XF:           next_state = StXfHdr;
        CP_OP_LOAD_BP:           next_state = StBpData;
`ifdef CP_DISPLAY_LIST_EN
        CP_OP_CALL_DL:           next_state = StDlAddr;
`endif
        default:                 unknown = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/cp_command_sequencer.sv
// Command Processor sequencer: fetches opcodes/operands from the deserializer,
// issues CP/XF/BP register writes and hands the byte port to the vertex loader
// during draws. Display-list calls are built only with CP_DISPLAY_LIST_EN.
module cp_command_sequencer
  import cp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        CPRead,
  output logic [2:0]  CPBytes,
  input  logic        CPValid,
  input  logic [31:0] CPData,
  output logic        CPRegWrite,
  output logic [7:0]  CPRegAddr,
  output logic        XFRegWrite,
  output logic [15:0] XFRegAddr,
  output logic        BPRegWrite,
  output logic [7:0]  BPRegAddr,
  output logic [31:0] RegData,
  output logic        VCInvalidate,
  output logic        DLCall,
  output logic [31:0] DLAddr,
  output logic [31:0] DLSize,
  output logic        DrawStart,
  output logic [2:0]  DrawPrim,
  output logic [2:0]  DrawVAT,
  output logic [15:0] DrawCount,
  input  logic        DrawDone,
  input  logic        VtxRead,
  input  logic [2:0]  VtxBytes,
  output logic        VtxValid,
  output logic [31:0] VtxData,
  output logic        CmdError
);

  cp_state_e   state_q, state_d, dec_state;
  logic [3:0]  dec_state_raw;
  logic [2:0]  dec_prim, dec_vat;
  logic        dec_unknown;
  logic        xfer;
  // Holds the byte port idle for the first cycle after reset.
  logic        active_q;
  logic        cp_write_q, xf_write_q, bp_write_q, inv_q, draw_start_q, err_q;
  logic [7:0]  cp_addr_q, bp_addr_q;
  logic [15:0] xf_addr_q, xf_ptr_q, count_q;
  logic [16:0] xf_left_q;
  logic [31:0] reg_data_q;
  logic [2:0]  prim_q, vat_q;
`ifdef CP_DISPLAY_LIST_EN
  logic        dl_call_q;
  logic [31:0] dl_addr_q, dl_size_q;
`endif

  cp_opcode_decoder u_decoder (
    .opcode     (CPData[7:0]),
    .next_state (dec_state_raw),
    .prim       (dec_prim),
    .vat        (dec_vat),
    .unknown    (dec_unknown)
  );

  assign dec_state = cp_state_e'(dec_state_raw);

  // Byte-port control: parser fetches outside draws, loader pass-through inside.
  always_comb begin
    CPRead   = active_q;
    CPBytes  = state_bytes(state_q);
    VtxValid = 1'b0;
    VtxData  = '0;
    if (state_q == StDraw) begin
      CPRead   = VtxRead;
      CPBytes  = VtxBytes;
      VtxValid = CPValid;
      VtxData  = CPData;
    end
  end

  assign xfer = CPRead & CPValid;

  // Parser next state, advancing only on completed transfers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StOpcode:    if (xfer) state_d = dec_state;
      StCpAddr:    if (xfer) state_d = StCpData;
      StCpData:    if (xfer) state_d = StOpcode;
      StXfHdr:     if (xfer) state_d = StXfData;
      StXfData:    if (xfer && xf_left_q == 17'd1) state_d = StOpcode;
      StBpData:    if (xfer) state_d = StOpcode;
`ifdef CP_DISPLAY_LIST_EN
      StDlAddr:    if (xfer) state_d = StDlSize;
      StDlSize:    if (xfer) state_d = StOpcode;
`endif
      StDrawCount: if (xfer) state_d = (CPData[15:0] == 16'd0) ? StOpcode : StDraw;
      StDraw:      if (DrawDone) state_d = StOpcode;
      default:     state_d = StOpcode;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StOpcode;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture and single-cycle strobes following each completing transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= 1'b0;
      cp_write_q   <= 1'b0;
      xf_write_q   <= 1'b0;
      bp_write_q   <= 1'b0;
      inv_q        <= 1'b0;
      draw_start_q <= 1'b0;
      err_q        <= 1'b0;
      cp_addr_q    <= '0;
      bp_addr_q    <= '0;
      xf_addr_q    <= '0;
      xf_ptr_q     <= '0;
      xf_left_q    <= '0;
      count_q      <= '0;
      reg_data_q   <= '0;
      prim_q       <= '0;
      vat_q        <= '0;
`ifdef CP_DISPLAY_LIST_EN
      dl_call_q    <= 1'b0;
      dl_addr_q    <= '0;
      dl_size_q    <= '0;
`endif
    end else begin
      active_q     <= 1'b1;
      cp_write_q   <= 1'b0;
      xf_write_q   <= 1'b0;
      bp_write_q   <= 1'b0;
      inv_q        <= 1'b0;
      draw_start_q <= 1'b0;
`ifdef CP_DISPLAY_LIST_EN
      dl_call_q    <= 1'b0;
`endif
      if (xfer) begin
        case (state_q)
          StOpcode: begin
            if (CPData[7:0] == CP_OP_INV_VC) inv_q <= 1'b1;
            if (dec_unknown) err_q <= 1'b1;
            if (dec_state == StDrawCount) begin
              prim_q <= dec_prim;
              vat_q  <= dec_vat;
            end
          end
          StCpAddr: cp_addr_q <= CPData[7:0];
          StCpData: begin
            cp_write_q <= 1'b1;
            reg_data_q <= CPData;
          end
          StXfHdr: begin
            xf_ptr_q  <= CPData[15:0];
            // Header holds length-1; a 17-bit count allows 65536 words.
            xf_left_q <= {1'b0, CPData[31:16]} + 17'd1;
          end
          StXfData: begin
            xf_write_q <= 1'b1;
            xf_addr_q  <= xf_ptr_q;
            reg_data_q <= CPData;
            xf_ptr_q   <= xf_ptr_q + 16'd1;
            xf_left_q  <= xf_left_q - 17'd1;
          end
          StBpData: begin
            bp_write_q <= 1'b1;
            bp_addr_q  <= CPData[31:24];
            reg_data_q <= {8'h00, CPData[23:0]};
          end
`ifdef CP_DISPLAY_LIST_EN
          StDlAddr: dl_addr_q <= CPData;
          StDlSize: begin
            dl_call_q <= 1'b1;
            dl_size_q <= CPData;
          end
`endif
          StDrawCount: begin
            if (CPData[15:0] != 16'd0) begin
              draw_start_q <= 1'b1;
              count_q      <= CPData[15:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign CPRegWrite   = cp_write_q;
  assign CPRegAddr    = cp_addr_q;
  assign XFRegWrite   = xf_write_q;
  assign XFRegAddr    = xf_addr_q;
  assign BPRegWrite   = bp_write_q;
  assign BPRegAddr    = bp_addr_q;
  assign RegData      = reg_data_q;
  assign VCInvalidate = inv_q;
  assign DrawStart    = draw_start_q;
  assign DrawPrim     = prim_q;
  assign DrawVAT      = vat_q;
  assign DrawCount    = count_q;
  assign CmdError     = err_q;
`ifdef CP_DISPLAY_LIST_EN
  assign DLCall       = dl_call_q;
  assign DLAddr       = dl_addr_q;
  assign DLSize       = dl_size_q;
`else
  assign DLCall       = 1'b0;
  assign DLAddr       = '0;
  assign DLSize       = '0;
`endif

endmodule

// File: tb/tb_cp_command_sequencer.sv
// Bench for cp_command_sequencer. Commands are expanded into a queue of
// deserializer chunks plus a queue of expected register-side events; a per-cycle
// stepper plays deserializer and vertex loader and checks every cycle.
module tb_cp_command_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        CPRead;
  logic [2:0]  CPBytes;
  logic        CPValid;
  logic [31:0] CPData;
  logic        CPRegWrite;
  logic [7:0]  CPRegAddr;
  logic        XFRegWrite;
  logic [15:0] XFRegAddr;
  logic        BPRegWrite;
  logic [7:0]  BPRegAddr;
  logic [31:0] RegData;
  logic        VCInvalidate;
  logic        DLCall;
  logic [31:0] DLAddr;
  logic [31:0] DLSize;
  logic        DrawStart;
  logic [2:0]  DrawPrim;
  logic [2:0]  DrawVAT;
  logic [15:0] DrawCount;
  logic        DrawDone;
  logic        VtxRead;
  logic [2:0]  VtxBytes;
  logic        VtxValid;
  logic [31:0] VtxData;
  logic        CmdError;

  always #5 clk = ~clk;

  cp_command_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .CPRead       (CPRead),
    .CPBytes      (CPBytes),
    .CPValid      (CPValid),
    .CPData       (CPData),
    .CPRegWrite   (CPRegWrite),
    .CPRegAddr    (CPRegAddr),
    .XFRegWrite   (XFRegWrite),
    .XFRegAddr    (XFRegAddr),
    .BPRegWrite   (BPRegWrite),
    .BPRegAddr    (BPRegAddr),
    .RegData      (RegData),
    .VCInvalidate (VCInvalidate),
    .DLCall       (DLCall),
    .DLAddr       (DLAddr),
    .DLSize       (DLSize),
    .DrawStart    (DrawStart),
    .DrawPrim     (DrawPrim),
    .DrawVAT      (DrawVAT),
    .DrawCount    (DrawCount),
    .DrawDone     (DrawDone),
    .VtxRead      (VtxRead),
    .VtxBytes     (VtxBytes),
    .VtxValid     (VtxValid),
    .VtxData      (VtxData),
    .CmdError     (CmdError)
  );

  // Event kinds: 1 CP write, 2 XF write, 3 BP write, 4 VC invalidate,
  // 5 DL call, 6 draw start.
  typedef struct {
    int unsigned n;
    logic [31:0] val;
    bit          ev;
    bit          err;
  } chunk_t;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  chunk_t      bq[$];
  ev_t         exq[$];
  int          tests;
  int          fails;
  int unsigned gap_pct;
  bit          pending;
  bit          in_draw;
  bit          exp_err;
  int          vtx_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void put(input int unsigned n, input logic [31:0] v, input bit ev,
                              input bit err);
    chunk_t c;
    c.n = n; c.val = v; c.ev = ev; c.err = err;
    bq.push_back(c);
  endfunction

  function automatic void expect_ev(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exq.push_back(e);
  endfunction

  function automatic void clear_model();
    bq.delete();
    exq.delete();
    pending  = 1'b0;
    in_draw  = 1'b0;
    exp_err  = 1'b0;
    vtx_left = 0;
  endfunction

  function automatic void cmd_cp(input logic [7:0] a, input logic [31:0] d);
    put(1, 32'h08, 1'b0, 1'b0);
    put(1, {24'h0, a}, 1'b0, 1'b0);
    put(4, d, 1'b1, 1'b0);
    expect_ev(1, {24'h0, a}, d);
  endfunction

  function automatic void cmd_xf(input logic [15:0] start, input int len);
    logic [15:0] a;
    logic [15:0] lm1;
    logic [31:0] w;
    lm1 = 16'(len - 1);
    put(1, 32'h10, 1'b0, 1'b0);
    put(4, {lm1, start}, 1'b0, 1'b0);
    a = start;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      put(4, w, 1'b1, 1'b0);
      expect_ev(2, {16'h0, a}, w);
      a = a + 16'd1;
    end
  endfunction

  function automatic void cmd_bp(input logic [31:0] v);
    put(1, 32'h61, 1'b0, 1'b0);
    put(4, v, 1'b1, 1'b0);
    expect_ev(3, {24'h0, v[31:24]}, {8'h0, v[23:0]});
  endfunction

  function automatic void cmd_inv();
    put(1, 32'h48, 1'b1, 1'b0);
    expect_ev(4, 32'h0, 32'h0);
  endfunction

  function automatic void cmd_nop();
    put(1, 32'h00, 1'b0, 1'b0);
  endfunction

  function automatic void cmd_bad(input logic [7:0] op);
    put(1, {24'h0, op}, 1'b0, 1'b1);
  endfunction

  function automatic void cmd_draw(input logic [7:0] op, input int cnt);
    put(1, {24'h0, op}, 1'b0, 1'b0);
    if (cnt == 0) begin
      put(2, 32'h0, 1'b0, 1'b0);
    end else begin
      put(2, 32'(cnt), 1'b1, 1'b0);
      expect_ev(6, {26'h0, op[5:0]}, 32'(cnt));
      for (int i = 0; i < cnt; i++) put(4, $urandom, 1'b0, 1'b0);
    end
  endfunction

  function automatic void cmd_dl(input logic [31:0] a, input logic [31:0] s);
`ifdef CP_DISPLAY_LIST_EN
    put(1, 32'h40, 1'b0, 1'b0);
    put(4, a, 1'b0, 1'b0);
    put(4, s, 1'b1, 1'b0);
    expect_ev(5, a, s);
`else
    if (a == s) put(1, 32'h40, 1'b0, 1'b1);
    else cmd_bad(8'h40);
`endif
  endfunction

  function automatic bit is_known(input logic [7:0] op);
    bit k;
    k = (op == 8'h00) || (op == 8'h08) || (op == 8'h10) || (op == 8'h61) ||
        (op == 8'h48) || (op[7:6] == 2'b10);
`ifdef CP_DISPLAY_LIST_EN
    k = k || (op == 8'h40);
`endif
    return k;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    int          nstb;
    int          k;
    logic [31:0] a;
    logic [31:0] d;
    ev_t         e;
    chunk_t      c;
    bit          xfer;
    bit          done;
    nstb = int'(CPRegWrite) + int'(XFRegWrite) + int'(BPRegWrite) + int'(VCInvalidate) +
           int'(DLCall) + int'(DrawStart);
    check("strobe_count", 32'(nstb), pending ? 32'd1 : 32'd0);
    k = 0; a = '0; d = '0;
    if (CPRegWrite)        begin k = 1; a = {24'h0, CPRegAddr}; d = RegData; end
    else if (XFRegWrite)   begin k = 2; a = {16'h0, XFRegAddr}; d = RegData; end
    else if (BPRegWrite)   begin k = 3; a = {24'h0, BPRegAddr}; d = RegData; end
    else if (VCInvalidate) begin k = 4; end
    else if (DLCall)       begin k = 5; a = DLAddr; d = DLSize; end
    else if (DrawStart)    begin k = 6; a = {26'h0, DrawPrim, DrawVAT}; d = {16'h0, DrawCount}; end
    if (pending) begin
      e = exq.pop_front();
      if (nstb == 1) begin
        check("event_kind", 32'(k), 32'(e.kind));
        if (e.kind != 4) begin
          check("event_addr", a, e.addr);
          check("event_data", d, e.data);
        end
      end
      if (e.kind == 6) begin
        in_draw  = 1'b1;
        vtx_left = int'(e.data);
      end
    end
    pending = 1'b0;
    check("cmd_error", {31'h0, CmdError}, {31'h0, exp_err});

    DrawDone = 1'b0;
    VtxBytes = 3'd4;
    VtxRead  = in_draw && vtx_left > 0 && $urandom_range(99) >= gap_pct;
    #1;
    if (bq.size() > 0 && $urandom_range(99) >= gap_pct) begin
      CPValid = 1'b1;
      CPData  = bq[0].val;
    end else begin
      CPValid = 1'b0;
      CPData  = $urandom;
    end
    #1;
    if (in_draw) begin
      check("draw_cpread", {31'h0, CPRead}, {31'h0, VtxRead});
    end else begin
      check("idle_cpread", {31'h0, CPRead}, 32'd1);
      check("idle_vtxvalid", {31'h0, VtxValid}, 32'd0);
      check("idle_vtxdata", VtxData, 32'd0);
    end
    xfer = CPRead && CPValid;
    done = 1'b0;
    if (in_draw && ((vtx_left == 1 && xfer && $urandom_range(1) == 1) || vtx_left == 0)) begin
      DrawDone = 1'b1;
      done     = 1'b1;
    end
    if (xfer && bq.size() > 0) begin
      c = bq.pop_front();
      check("cp_bytes", {29'h0, CPBytes}, 32'(c.n));
      if (in_draw) begin
        check("vtx_valid", {31'h0, VtxValid}, 32'd1);
        check("vtx_data", VtxData, c.val);
        vtx_left--;
      end
      pending = c.ev;
      if (c.err) exp_err = 1'b1;
    end
    @(posedge clk);
    if (done) in_draw = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input int budget, output int cycles);
    cycles = 0;
    while ((bq.size() > 0 || pending || in_draw) && cycles < budget) begin
      step();
      cycles++;
    end
    check("run_timeout", {31'h0, (cycles >= budget)}, 32'd0);
    check("events_left", 32'(exq.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_cpread", {31'h0, CPRead}, 32'd0);
    check("rst_cpbytes", {29'h0, CPBytes}, 32'd1);
    check("rst_strobes", {26'h0, CPRegWrite, XFRegWrite, BPRegWrite, VCInvalidate, DLCall,
                          DrawStart}, 32'd0);
    check("rst_cpaddr", {24'h0, CPRegAddr}, 32'd0);
    check("rst_xfaddr", {16'h0, XFRegAddr}, 32'd0);
    check("rst_bpaddr", {24'h0, BPRegAddr}, 32'd0);
    check("rst_regdata", RegData, 32'd0);
    check("rst_dladdr", DLAddr, 32'd0);
    check("rst_dlsize", DLSize, 32'd0);
    check("rst_draw", {10'h0, DrawPrim, DrawVAT, DrawCount}, 32'd0);
    check("rst_vtx", {31'h0, VtxValid}, 32'd0);
    check("rst_vtxdata", VtxData, 32'd0);
    check("rst_cmderror", {31'h0, CmdError}, 32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    CPValid  = 1'b0;
    DrawDone = 1'b0;
    VtxRead  = 1'b0;
    @(negedge clk);
    check_reset_values();
    clear_model();
    reset = 1'b0;
    @(negedge clk);
    check("cpread_rise", {31'h0, CPRead}, 32'd1);
  endtask

  initial begin
    int          cyc;
    int          sel;
    logic [7:0]  op;
    reset    = 1'b1;
    CPValid  = 1'b0;
    CPData   = '0;
    DrawDone = 1'b0;
    VtxRead  = 1'b0;
    VtxBytes = 3'd4;
    tests    = 0;
    fails    = 0;
    gap_pct  = 0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Back-to-back CP load: three fetches then the strobe, no bubbles.
    cmd_cp(8'h30, 32'h12345678);
    run(200, cyc);
    check("cp_load_cycles", 32'(cyc), 32'd4);
    check("opcode_bytes", {29'h0, CPBytes}, 32'd1);

    cmd_xf(16'h1000, 3);
    cmd_xf(16'hFFFF, 2);
    run(200, cyc);

    gap_pct = 50;
    cmd_bp(32'h4900ABCD);
    run(500, cyc);

    gap_pct = 0;
    cmd_draw(8'h90, 3);
    cmd_draw(8'h88, 0);
    cmd_inv();
    run(500, cyc);

    cmd_bad(8'h33);
    cmd_nop();
    cmd_cp(8'h01, 32'hCAFEF00D);
    cmd_dl(32'h8000_1000, 32'h0000_0040);
    run(500, cyc);
    check("sticky_error", {31'h0, CmdError}, 32'd1);

    gap_pct = 30;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(6));
      case (sel)
        0: cmd_cp(8'($urandom), $urandom);
        1: cmd_xf(16'($urandom), int'($urandom_range(1, 4)));
        2: cmd_bp($urandom);
        3: cmd_inv();
        4: cmd_draw(8'h80 | 8'($urandom_range(63)), int'($urandom_range(4)));
        5: cmd_nop();
        default: begin
          op = 8'($urandom);
          while (is_known(op)) op = 8'($urandom);
          cmd_bad(op);
        end
      endcase
    end
    run(20000, cyc);

    // Reset in the middle of an XF block discards it and clears the sticky flag.
    gap_pct = 0;
    cmd_xf(16'h2000, 8);
    repeat (5) step();
    do_reset();
    cmd_inv();
    run(200, cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cp_command_sequencer.md
# cp_command_sequencer

Command opcode parser and byte-stream owner for the Command Processor, placed between the command deserializer and the register/vertex consumers. Requests opcode and operand bytes from the deserializer, decodes GX FIFO commands (NOP, CP/XF/BP register loads, cache invalidate, display-list call, draws) and issues register-write strobes. During draws it hands the deserializer port to the vertex loader until that loader signals completion.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- CPRead  out  1  byte request to deserializer
- CPBytes  out  3  bytes requested (1, 2 or 4)
- CPValid  in  1  deserializer data valid
- CPData  in  32  requested bytes, big-endian, right-aligned in [8*N-1:0]
- CPRegWrite  out  1  CP register write strobe
- CPRegAddr  out  8  CP register address
- XFRegWrite  out  1  XF register write strobe
- XFRegAddr  out  16  XF register address
- BPRegWrite  out  1  BP register write strobe
- BPRegAddr  out  8  BP register address
- RegData  out  32  data for the active write strobe (BP uses [23:0])
- VCInvalidate  out  1  vertex cache invalidate pulse
- DLCall  out  1  display-list call pulse
- DLAddr  out  32  display-list address
- DLSize  out  32  display-list size
- DrawStart  out  1  draw start pulse
- DrawPrim  out  3  primitive type, opcode[5:3]
- DrawVAT  out  3  VAT index, opcode[2:0]
- DrawCount  out  16  vertex count
- DrawDone  in  1  vertex loader done, single-cycle pulse
- VtxRead  in  1  vertex loader byte request
- VtxBytes  in  3  vertex loader byte count
- VtxValid  out  1  vertex loader data valid
- VtxData  out  32  vertex loader data
- CmdError  out  1  sticky unknown-opcode flag

## Operation
- Transfer rule: a transfer occurs on a cycle with CPRead && CPValid. CPBytes must stay constant while CPRead is high.
- FSM states: OPCODE, CP_ADDR, CP_DATA, XF_HDR, XF_DATA, BP_DATA, DL_ADDR, DL_SIZE, DRAW_COUNT, DRAW.
- OPCODE: requests 1 byte, then decodes it:
  - 0x00 (NOP): stay in OPCODE.
  - 0x08: go to CP_ADDR (1 byte), then CP_DATA (4 bytes); pulse CPRegWrite.
  - 0x10: go to XF_HDR (4 bytes). Header [31:16] = length-1, [15:0] = start address. Then XF_DATA reads length words, pulsing XFRegWrite per word. Address increments by 1 per word and wraps at 16 bits. Length counter is 17 bits (max 65536).
  - 0x61: go to BP_DATA (4 bytes). BPRegAddr = [31:24], RegData = {8'h0, [23:0]}; pulse BPRegWrite.
  - 0x48: pulse VCInvalidate; stay in OPCODE.
  - 0x40: go to DL_ADDR (4 bytes), then DL_SIZE (4 bytes); pulse DLCall. Only when the macro is defined.
  - 0x80–0xBF: latch DrawPrim and DrawVAT, go to DRAW_COUNT (2 bytes).
  - Any other value: set CmdError, stay in OPCODE, discard the byte.
- DRAW_COUNT:
  - Count = 0: return to OPCODE, no DrawStart.
  - Otherwise: pulse DrawStart with DrawCount, enter DRAW.
- DRAW: combinational pass-through.
  - CPRead = VtxRead, CPBytes = VtxBytes, VtxValid = CPValid, VtxData = CPData.
  - On DrawDone, go to OPCODE. If DrawDone and a vertex transfer occur in the same cycle, the transfer completes first.
- Outside DRAW: VtxValid = 0 and VtxData = 0.

## Timing
- Reset values: all strobes 0, CmdError 0, all address/data/Draw* outputs 0, CPRead 0, CPBytes 1, state OPCODE.
- CPRead rises the first cycle after reset deasserts.
- CPRead stays high in every fetch state. Back-to-back transfers are sustained at 1 per cycle with no bubble between operand fetches.
- Strobes (CPRegWrite, XFRegWrite, BPRegWrite, VCInvalidate, DLCall, DrawStart) are registered: they assert for exactly one cycle, the cycle after the completing transfer. Address/data outputs are valid in the same cycle.
- Opcode accepted at cycle N → next fetch requested at N+1.
- DrawStart and entry to DRAW happen in the same cycle. Pass-through is active from that cycle.
- Reset mid-command: the partial command is discarded. Sticky CmdError is cleared only by reset.

## Configuration
- CP_DISPLAY_LIST_EN
  - Defined: 0x40 is decoded; the DL_ADDR and DL_SIZE states exist; DLCall, DLAddr and DLSize are driven.
  - Undefined: 0x40 is an unknown opcode (sets CmdError, 1 byte consumed); DLCall, DLAddr and DLSize are tied to 0.

## Structure
- Shared package cp_pkg holds:
  - Opcode constants: CP_OP_NOP, CP_OP_LOAD_CP, CP_OP_LOAD_XF, CP_OP_LOAD_BP, CP_OP_INV_VC, CP_OP_CALL_DL, CP_OP_DRAW_MASK.
  - FSM state enum.
  - Byte-count constants.
- One sub-module: cp_opcode_decoder. It is purely combinational: opcode byte → next state, primitive and VAT fields, and unknown flag.

## Test plan
- Stream 0x08, 0x30, 0x12345678 → CPRegWrite one pulse, CPRegAddr=0x30, RegData=0x12345678, then OPCODE requests 1 byte.
- 0x10, header 0x00021000, words A/B/C → three XFRegWrite pulses at addresses 0x1000, 0x1001, 0x1002. Repeat with start address 0xFFFF and length 2 → writes to 0xFFFF then 0x0000.
- 0x61, 0x4900ABCD → BPRegAddr=0x49, RegData=0x0000ABCD; insert CPValid gaps → no strobe until the transfer completes.
- 0x90, count 0x0003 → DrawStart, DrawPrim=2, DrawVAT=0, DrawCount=3. Loader reads 3×4 bytes via pass-through, pulses DrawDone → next opcode fetched. Count 0x0000 → no DrawStart.
- Byte 0x33 → CmdError=1; a following 0x00 NOP is accepted normally. With the macro undefined, 0x40 → CmdError=1.
- Reset asserted during XF_DATA → all outputs at reset values next cycle; a fresh 0x48 → VCInvalidate pulse.
